worker: RTL and testbench



---
 rtl/worker.sv | 197 +++++++++++++++++++
 tb/tb_worker.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/worker.sv
// Dataflow CPU execution unit: accepts one fired instruction packet at a time
// and emits one or two result tokens toward the matching stage.
// Optional feature: define WORKER_MINUS_EN to execute INSN_MINUS (D1 - D2);
// without it opcode 8'h06 is treated as unknown and dropped.
module worker #(
  parameter int unsigned OPCODE_WIDTH        = 8,
  parameter int unsigned PACKET_WIDTH        = 2 + OPCODE_WIDTH + 4 * 32 + 3 + 16 + 16,
  parameter int unsigned WORKER_RESULT_WIDTH = 3 + 16 + 16 + 32
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           RECEIVE_PC_VALID,
  output logic                           RECEIVE_PC_READY,
  input  logic [PACKET_WIDTH-1:0]        RECEIVE_PC_DATA,
  output logic                           SEND_WR_VALID,
  input  logic                           SEND_WR_READY,
  output logic [WORKER_RESULT_WIDTH-1:0] SEND_WR_DATA
);

  localparam logic [OPCODE_WIDTH-1:0] INSN_DISTRIBUTE = OPCODE_WIDTH'(8'h01);
  localparam logic [OPCODE_WIDTH-1:0] INSN_SWITCH     = OPCODE_WIDTH'(8'h02);
  localparam logic [OPCODE_WIDTH-1:0] INSN_SET_COLOR  = OPCODE_WIDTH'(8'h03);
  localparam logic [OPCODE_WIDTH-1:0] INSN_SYNC       = OPCODE_WIDTH'(8'h04);
  localparam logic [OPCODE_WIDTH-1:0] INSN_PLUS       = OPCODE_WIDTH'(8'h05);
`ifdef WORKER_MINUS_EN
  localparam logic [OPCODE_WIDTH-1:0] INSN_MINUS      = OPCODE_WIDTH'(8'h06);
`endif

  // Packet field positions (LSB of each field), MSB to LSB:
  // flags, opcode, D1, D2, D3, D4, dest_option, dest_addr, color
  localparam int unsigned ColorLsb = 0;
  localparam int unsigned AddrLsb  = 16;
  localparam int unsigned OptLsb   = 32;
  localparam int unsigned D4Lsb    = 35;
  localparam int unsigned D3Lsb    = 67;
  localparam int unsigned D2Lsb    = 99;
  localparam int unsigned D1Lsb    = 131;
  localparam int unsigned OpLsb    = 163;
  localparam int unsigned FlagsLsb = OpLsb + OPCODE_WIDTH;

  typedef enum logic [1:0] {
    StIdleRst,
    StIdle,
    StOut1,
    StOut2
  } state_e;

  // Unpacked view of the incoming packet
  logic [OPCODE_WIDTH-1:0] in_opcode;
  logic [31:0]             in_d1;
  logic [31:0]             in_d2;
  logic [31:0]             in_d3;
  logic [31:0]             in_d4;
  logic [2:0]              in_opt;
  logic [15:0]             in_addr;
  logic [15:0]             in_color;
  logic [1:0]              in_flags;

  assign in_opcode = RECEIVE_PC_DATA[OpLsb +: OPCODE_WIDTH];
  assign in_d1     = RECEIVE_PC_DATA[D1Lsb +: 32];
  assign in_d2     = RECEIVE_PC_DATA[D2Lsb +: 32];
  assign in_d3     = RECEIVE_PC_DATA[D3Lsb +: 32];
  assign in_d4     = RECEIVE_PC_DATA[D4Lsb +: 32];
  assign in_opt    = RECEIVE_PC_DATA[OptLsb +: 3];
  assign in_addr   = RECEIVE_PC_DATA[AddrLsb +: 16];
  assign in_color  = RECEIVE_PC_DATA[ColorLsb +: 16];
  assign in_flags  = RECEIVE_PC_DATA[FlagsLsb +: 2];

  // Flags and the upper bits of destination-carrying operands carry no meaning here
  logic unused_bits;
  assign unused_bits = ^{in_flags, in_d3[31:19], in_d4[31:19]};

  // Result token layout: {dest_option, dest_addr, color, data}
  function automatic logic [WORKER_RESULT_WIDTH-1:0] mk_tok(input logic [18:0] dst,
                                                           input logic [15:0] col,
                                                           input logic [31:0] data);
    return {dst, col, data};
  endfunction

  logic                           dec_known;
  logic                           dec_two;
  logic [WORKER_RESULT_WIDTH-1:0] dec_tok1;
  logic [WORKER_RESULT_WIDTH-1:0] dec_tok2;

  // Decode the presented packet into its token(s); only used on acceptance
  always_comb begin
    dec_known = 1'b1;
    dec_two   = 1'b0;
    dec_tok1  = '0;
    dec_tok2  = '0;
    case (in_opcode)
      INSN_DISTRIBUTE: begin
        dec_two  = 1'b1;
        dec_tok1 = mk_tok(in_d2[18:0], in_color, in_d1);
        dec_tok2 = mk_tok(in_d3[18:0], in_color, in_d1);
      end
      INSN_SWITCH: begin
        // Any nonzero bit of D2 selects the D3 destination
        dec_tok1 = (in_d2 != 32'h0) ? mk_tok(in_d3[18:0], in_color, in_d1)
                                    : mk_tok(in_d4[18:0], in_color, in_d1);
      end
      INSN_SET_COLOR: begin
        dec_tok1 = mk_tok({in_opt, in_addr}, in_d2[15:0], in_d1);
      end
      INSN_SYNC: begin
        dec_two  = 1'b1;
        dec_tok1 = mk_tok(in_d3[18:0], in_color, in_d1);
        dec_tok2 = mk_tok(in_d4[18:0], in_color, in_d2);
      end
      INSN_PLUS: begin
        dec_tok1 = mk_tok({in_opt, in_addr}, in_color, in_d1 + in_d2);
      end
`ifdef WORKER_MINUS_EN
      INSN_MINUS: begin
        dec_tok1 = mk_tok({in_opt, in_addr}, in_color, in_d1 - in_d2);
      end
`endif
      default: begin
        dec_known = 1'b0;
      end
    endcase
  end

  state_e                         state_q, state_d;
  logic [WORKER_RESULT_WIDTH-1:0] out_q, out_d;
  logic [WORKER_RESULT_WIDTH-1:0] tok2_q, tok2_d;
  logic                           two_q, two_d;
  logic                           ready;
  logic                           valid;

  // State and token registers; reset discards any pending tokens at once
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StIdleRst;
      out_q   <= '0;
      tok2_q  <= '0;
      two_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      tok2_q  <= tok2_d;
      two_q   <= two_d;
    end
  end

  // Next-state, token sequencing and handshake outputs
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    tok2_d  = tok2_q;
    two_d   = two_q;
    ready   = 1'b0;
    valid   = 1'b0;
    case (state_q)
      StIdleRst: begin
        state_d = StIdle;
      end
      StIdle: begin
        ready = 1'b1;
        // Unknown opcodes are consumed but produce nothing
        if (RECEIVE_PC_VALID && dec_known) begin
          state_d = StOut1;
          out_d   = dec_tok1;
          tok2_d  = dec_tok2;
          two_d   = dec_two;
        end
      end
      StOut1: begin
        valid = 1'b1;
        if (SEND_WR_READY) begin
          if (two_q) begin
            state_d = StOut2;
            out_d   = tok2_q;
          end else begin
            state_d = StIdle;
            out_d   = '0;
          end
        end
      end
      StOut2: begin
        valid = 1'b1;
        if (SEND_WR_READY) begin
          state_d = StIdle;
          out_d   = '0;
        end
      end
      default: begin
        state_d = StIdleRst;
      end
    endcase
  end

  assign RECEIVE_PC_READY = ready;
  assign SEND_WR_VALID    = valid;
  assign SEND_WR_DATA     = out_q;

endmodule

// File: tb/tb_worker.sv
// Self-checking bench for worker: directed packets from the test plan, a
// backpressure loop and randomized packets checked against a token model.
module tb_worker;

  localparam int unsigned PW = 173;
  localparam int unsigned RW = 67;

  logic          CLK = 1'b0;
  logic          RST;
  logic          RECEIVE_PC_VALID;
  logic          RECEIVE_PC_READY;
  logic [PW-1:0] RECEIVE_PC_DATA;
  logic          SEND_WR_VALID;
  logic          SEND_WR_READY;
  logic [RW-1:0] SEND_WR_DATA;

  always #5 CLK = ~CLK;

  worker #(
    .OPCODE_WIDTH       (8),
    .PACKET_WIDTH       (PW),
    .WORKER_RESULT_WIDTH(RW)
  ) dut (
    .CLK             (CLK),
    .RST             (RST),
    .RECEIVE_PC_VALID(RECEIVE_PC_VALID),
    .RECEIVE_PC_READY(RECEIVE_PC_READY),
    .RECEIVE_PC_DATA (RECEIVE_PC_DATA),
    .SEND_WR_VALID   (SEND_WR_VALID),
    .SEND_WR_READY   (SEND_WR_READY),
    .SEND_WR_DATA    (SEND_WR_DATA)
  );

  int            n_checks = 0;
  int            n_errors = 0;
  logic [RW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] pack(input logic [1:0] flags, input logic [7:0] op,
                                         input logic [31:0] d1, input logic [31:0] d2,
                                         input logic [31:0] d3, input logic [31:0] d4,
                                         input logic [2:0] opt, input logic [15:0] addr,
                                         input logic [15:0] color);
    return {flags, op, d1, d2, d3, d4, opt, addr, color};
  endfunction

  // Reference: the list of tokens each instruction must produce
  task automatic model(input logic [7:0] op, input logic [31:0] d1, input logic [31:0] d2,
                       input logic [31:0] d3, input logic [31:0] d4, input logic [2:0] opt,
                       input logic [15:0] addr, input logic [15:0] c);
    logic [31:0] sum;
    logic [31:0] diff;
    sum  = d1 + d2;
    diff = d1 - d2;
    case (op)
      8'h01: begin
        exp_q.push_back({d2[18:0], c, d1});
        exp_q.push_back({d3[18:0], c, d1});
      end
      8'h02: exp_q.push_back((d2 != 0) ? {d3[18:0], c, d1} : {d4[18:0], c, d1});
      8'h03: exp_q.push_back({opt, addr, d2[15:0], d1});
      8'h04: begin
        exp_q.push_back({d3[18:0], c, d1});
        exp_q.push_back({d4[18:0], c, d2});
      end
      8'h05: exp_q.push_back({opt, addr, c, sum});
`ifdef WORKER_MINUS_EN
      8'h06: exp_q.push_back({opt, addr, c, diff});
`endif
      default: ;
    endcase
  endtask

  // Present one packet, then drain and check every expected token.
  // hold >= 0: SEND_WR_READY low for that many cycles per token; hold < 0: random.
  task automatic run_pkt(input string tag, input logic [7:0] op, input logic [31:0] d1,
                         input logic [31:0] d2, input logic [31:0] d3, input logic [31:0] d4,
                         input logic [2:0] opt, input logic [15:0] addr,
                         input logic [15:0] color, input int hold);
    logic [RW-1:0] e;
    logic          bp;
    int            stall;
    exp_q.delete();
    model(op, d1, d2, d3, d4, opt, addr, color);
    @(negedge CLK);
    check1({tag, ".pc_ready"}, RECEIVE_PC_READY, 1'b1);
    RECEIVE_PC_VALID = 1'b1;
    RECEIVE_PC_DATA  = pack(2'($urandom_range(0, 3)), op, d1, d2, d3, d4, opt, addr, color);
    @(posedge CLK);
    @(negedge CLK);
    RECEIVE_PC_VALID = 1'b0;
    RECEIVE_PC_DATA  = '0;
    while (exp_q.size() != 0) begin
      e     = exp_q.pop_front();
      stall = 0;
      bp    = 1'b0;
      while (!bp) begin
        if (hold >= 0) bp = (stall >= hold);
        else bp = (stall >= 6) ? 1'b1 : 1'($urandom_range(0, 1));
        SEND_WR_READY = bp;
        check1({tag, ".wr_valid"}, SEND_WR_VALID, 1'b1);
        check({tag, ".wr_data"}, SEND_WR_DATA, e);
        check1({tag, ".pc_ready_busy"}, RECEIVE_PC_READY, 1'b0);
        @(posedge CLK);
        stall++;
        @(negedge CLK);
      end
      SEND_WR_READY = 1'b0;
    end
    check1({tag, ".wr_valid_done"}, SEND_WR_VALID, 1'b0);
    check1({tag, ".pc_ready_done"}, RECEIVE_PC_READY, 1'b1);
  endtask

  initial begin
    logic [7:0]  ops[9];
    logic [7:0]  op;
    logic [31:0] d2;

    RST              = 1'b1;
    RECEIVE_PC_VALID = 1'b0;
    RECEIVE_PC_DATA  = '0;
    SEND_WR_READY    = 1'b0;

    // Reset behaviour
    repeat (3) @(negedge CLK);
    check1("rst.pc_ready", RECEIVE_PC_READY, 1'b0);
    check1("rst.wr_valid", SEND_WR_VALID, 1'b0);
    check("rst.wr_data", SEND_WR_DATA, '0);
    RST = 1'b0;
    #1;
    check1("rst_release.pc_ready", RECEIVE_PC_READY, 1'b0);
    @(negedge CLK);
    check1("idle.pc_ready", RECEIVE_PC_READY, 1'b1);
    check1("idle.wr_valid", SEND_WR_VALID, 1'b0);

    // Directed cases from the test plan (upper operand bits deliberately nonzero)
    run_pkt("distribute", 8'h01, 32'hdeadbeef, {13'h1abc, 3'b010, 16'hdead},
            {13'h0f0f, 3'b101, 16'hbeef}, 32'h0, 3'b111, 16'h5555, 16'h0f0f, 0);
    run_pkt("switch_d2_1", 8'h02, 32'h1234abcd, 32'h1, {13'h1fff, 3'b000, 16'h0f0f},
            {13'h0001, 3'b111, 16'hf0f0}, 3'b001, 16'h1111, 16'habcd, 1);
    run_pkt("switch_d2_0", 8'h02, 32'h1234abcd, 32'h0, {13'h1fff, 3'b000, 16'h0f0f},
            {13'h0001, 3'b111, 16'hf0f0}, 3'b001, 16'h1111, 16'habcd, 0);
    run_pkt("switch_d2_hi", 8'h02, 32'h1234abcd, 32'h8000_0000, {13'h0, 3'b000, 16'h0f0f},
            {13'h0, 3'b111, 16'hf0f0}, 3'b001, 16'h1111, 16'habcd, 0);
    run_pkt("set_color", 8'h03, 32'habcd1234, 32'hffff_badc, 32'h0, 32'h0, 3'b001, 16'h0a0a,
            16'habcd, 0);
    run_pkt("sync", 8'h04, 32'hdeadbeef, 32'h43215678, {13'h0, 3'b100, 16'h8776},
            {13'h0, 3'b011, 16'h2030}, 3'b000, 16'h0, 16'h0f0f, 2);
    run_pkt("plus_wrap", 8'h05, 32'hffff_ffff, 32'h0000_0002, 32'h0, 32'h0, 3'b010, 16'h1234,
            16'h4321, 0);
    run_pkt("minus", 8'h06, 32'h0000_0001, 32'h0000_0003, 32'h0, 32'h0, 3'b011, 16'h7777,
            16'h2222, 0);
    run_pkt("unknown_00", 8'h00, 32'h1, 32'h2, 32'h3, 32'h4, 3'b101, 16'h1, 16'h2, 0);
    run_pkt("unknown_07", 8'h07, 32'h1, 32'h2, 32'h3, 32'h4, 3'b101, 16'h1, 16'h2, 0);

    // PLUS under 5 cycles of backpressure, ten times back to back
    for (int i = 0; i < 10; i++) begin
      run_pkt("plus_bp", 8'h05, 32'hdead0000, 32'h0000beef, 32'h0, 32'h0, 3'b110, 16'h00ff,
              16'heeee, 5);
    end

    // Reset while a two-token operation is pending
    @(negedge CLK);
    RECEIVE_PC_VALID = 1'b1;
    RECEIVE_PC_DATA  = pack(2'b00, 8'h01, 32'hcafef00d, 32'h0001_1234, 32'h0002_5678, 32'h0,
                            3'b000, 16'h0, 16'h0101);
    @(posedge CLK);
    @(negedge CLK);
    RECEIVE_PC_VALID = 1'b0;
    check1("midrst.wr_valid_before", SEND_WR_VALID, 1'b1);
    #1 RST = 1'b1;
    #1;
    check1("midrst.wr_valid", SEND_WR_VALID, 1'b0);
    check1("midrst.pc_ready", RECEIVE_PC_READY, 1'b0);
    check("midrst.wr_data", SEND_WR_DATA, '0);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    check1("midrst.idle_ready", RECEIVE_PC_READY, 1'b1);
    check1("midrst.idle_valid", SEND_WR_VALID, 1'b0);

    // Randomized packets with random backpressure
    ops = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h00, 8'h07, 8'hff};
    for (int i = 0; i < 80; i++) begin
      op = ops[$urandom_range(0, 8)];
      d2 = $urandom();
      if (op == 8'h02 && $urandom_range(0, 1) == 0) d2 = 32'h0;
      run_pkt("random", op, $urandom(), d2, $urandom(), $urandom(), 3'($urandom_range(0, 7)),
              16'($urandom()), 16'($urandom()), -1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
